// File: rtl/gpu_pkg.sv
// gpu_pkg: shared widths, screen limits, opcodes, FSM states and the queued
// command record for the gpu rasterizer.
package gpu_pkg;

   localparam int CHANNEL_BITS = 8;
   localparam int WIDTH_BITS   = 10;
   localparam int HEIGHT_BITS  = 9;
   localparam int COLOR_BITS   = 3 * CHANNEL_BITS;
   localparam int ADDR_BITS    = 1 + HEIGHT_BITS + WIDTH_BITS;

   localparam logic [WIDTH_BITS-1:0]  SCREEN_W = 10'd640;
   localparam logic [HEIGHT_BITS-1:0] SCREEN_H = 9'd480;
   localparam logic [WIDTH_BITS-1:0]  X_MAX    = 10'd639;
   localparam logic [HEIGHT_BITS-1:0] Y_MAX    = 9'd479;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_PIXEL = 3'd1,
      OP_RECT  = 3'd2,
      OP_CLEAR = 3'd3,
      OP_SWAP  = 3'd4
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_SWAP = 2'd2
   } state_e;

   // opcode is kept raw so that the undefined codes 5-7 survive the queue
   typedef struct packed {
      logic [2:0]             opcode;
      logic [COLOR_BITS-1:0]  color;
      logic [WIDTH_BITS-1:0]  x1;
      logic [HEIGHT_BITS-1:0] y1;
      logic [WIDTH_BITS-1:0]  x2;
      logic [HEIGHT_BITS-1:0] y2;
   } cmd_t;

   localparam int CMD_BITS = $bits(cmd_t);

   function automatic logic [WIDTH_BITS-1:0] min_x(input logic [WIDTH_BITS-1:0] a,
                                                    input logic [WIDTH_BITS-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [WIDTH_BITS-1:0] max_x(input logic [WIDTH_BITS-1:0] a,
                                                    input logic [WIDTH_BITS-1:0] b);
      return (a < b) ? b : a;
   endfunction

   function automatic logic [HEIGHT_BITS-1:0] min_y(input logic [HEIGHT_BITS-1:0] a,
                                                     input logic [HEIGHT_BITS-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [HEIGHT_BITS-1:0] max_y(input logic [HEIGHT_BITS-1:0] a,
                                                     input logic [HEIGHT_BITS-1:0] b);
      return (a < b) ? b : a;
   endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: command queue between the APB decode and the rasterizer.
// Ports: clk, n_rst (async active-low), push_i/din_i (write side),
// pop_i/dout_o (read side, head visible combinationally), empty_o, full_o
// (registered). A push while full is dropped even if a pop happens on the
// same edge.
module gpu_cmd_fifo
   import gpu_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                push_i,
   input  logic [CMD_BITS-1:0] din_i,
   input  logic                pop_i,
   output logic [CMD_BITS-1:0] dout_o,
   output logic                empty_o,
   output logic                full_o
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;
   localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);

   logic [CMD_BITS-1:0] mem_q [DEPTH];
   logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_BITS-1:0] count_q, count_d;
   logic                full_q, full_d;
   logic                push_ok_s, pop_ok_s;

   assign empty_o = (count_q == {CNT_BITS{1'b0}});
   assign full_o  = full_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // next pointers, occupancy and full flag
   always_comb begin
      push_ok_s = push_i && (count_q != DEPTH_C);
      pop_ok_s  = pop_i && (count_q != {CNT_BITS{1'b0}});
      wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_BITS'(1)) : wr_ptr_q;
      rd_ptr_d  = pop_ok_s ? (rd_ptr_q + PTR_BITS'(1)) : rd_ptr_q;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_BITS'(1);
         2'b01:   count_d = count_q - CNT_BITS'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == DEPTH_C);
   end

   // control state
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q <= {PTR_BITS{1'b0}};
         rd_ptr_q <= {PTR_BITS{1'b0}};
         count_q  <= {CNT_BITS{1'b0}};
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   // storage array, contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/gpu.sv
// gpu: APB-programmed 2D rasterizer writing pixels into an external SRAM.
// Ports: clk, n_rst (async active-low); APB write-only slave (pAddr_i,
// pDataWrite_i, pSel_i, pEnable_i, pWrite_i); SRAM controls CE0_o, CE1_o,
// LB_o, UB_o, R_W_o, OE_o, ZZ_o, SEM_o; pixel bus rgbdataout_o /
// adddataout_o; buffer_select_o; fifo_full_o. All outputs are registered.
// Registers: 0x0 COLOR, 0x4 P1, 0x8 P2, 0xC push command (opcode in [2:0]).
// Build option: define GPU_CLIP_EN to skip pixels outside the 640x480 field.
module gpu
   import gpu_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic [31:0] pAddr_i,
   input  logic [31:0] pDataWrite_i,
   input  logic        pSel_i,
   input  logic        pEnable_i,
   input  logic        pWrite_i,
   output logic        CE0_o,
   output logic        CE1_o,
   output logic        LB_o,
   output logic        UB_o,
   output logic        R_W_o,
   output logic        OE_o,
   output logic        ZZ_o,
   output logic        SEM_o,
   output logic [23:0] rgbdataout_o,
   output logic [19:0] adddataout_o,
   output logic        buffer_select_o,
   output logic        fifo_full_o
);

   logic        apb_wr_s, push_s, pop_s, fifo_empty_s, pix_ok_s;
   logic        unused_bits_s;
   cmd_t        push_cmd_s, head_s;
   logic [CMD_BITS-1:0] fifo_dout_s;

   logic [23:0] color_q, color_d, draw_color_q, draw_color_d;
   logic [18:0] p1_q, p1_d, p2_q, p2_d;
   state_e      state_q, state_d;
   logic [9:0]  cur_x_q, cur_x_d, x_lo_q, x_lo_d, x_hi_q, x_hi_d;
   logic [8:0]  cur_y_q, cur_y_d, y_hi_q, y_hi_d;
   logic        buf_sel_q, buf_sel_d;
   logic        r_w_q, r_w_d, ce0_q, ce0_d, ce1_q, ce1_d;
   logic [23:0] rgb_q, rgb_d;
   logic [19:0] addr_q, addr_d;

   assign apb_wr_s      = pSel_i & pEnable_i & pWrite_i;
   assign push_s        = apb_wr_s && (pAddr_i[3:2] == 2'd3);
   assign unused_bits_s = ^{pAddr_i[31:4], pAddr_i[1:0], pDataWrite_i[31:24]};
   assign head_s        = cmd_t'(fifo_dout_s);

   // command record assembled from the staging registers at push time
   always_comb begin
      push_cmd_s.opcode = pDataWrite_i[2:0];
      push_cmd_s.color  = color_q;
      push_cmd_s.x1     = p1_q[9:0];
      push_cmd_s.y1     = p1_q[18:10];
      push_cmd_s.x2     = p2_q[9:0];
      push_cmd_s.y2     = p2_q[18:10];
   end

   gpu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .push_i  (push_s),
      .din_i   (push_cmd_s),
      .pop_i   (pop_s),
      .dout_o  (fifo_dout_s),
      .empty_o (fifo_empty_s),
      .full_o  (fifo_full_o)
   );

   // APB staging register writes
   always_comb begin
      color_d = color_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      if (apb_wr_s) begin
         case (pAddr_i[3:2])
            2'd0:    color_d = pDataWrite_i[23:0];
            2'd1:    p1_d    = pDataWrite_i[18:0];
            2'd2:    p2_d    = pDataWrite_i[18:0];
            default: color_d = color_q;
         endcase
      end else begin
         color_d = color_q;
      end
   end

   // field clipping of the current raster position
   always_comb begin
`ifdef GPU_CLIP_EN
      pix_ok_s = (cur_x_q < SCREEN_W) && (cur_y_q < SCREEN_H);
`else
      pix_ok_s = 1'b1;
`endif
   end

   // rasterizer next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      cur_x_d      = cur_x_q;
      cur_y_d      = cur_y_q;
      x_lo_d       = x_lo_q;
      x_hi_d       = x_hi_q;
      y_hi_d       = y_hi_q;
      draw_color_d = draw_color_q;
      buf_sel_d    = buf_sel_q;
      rgb_d        = rgb_q;
      addr_d       = addr_q;
      pop_s        = 1'b0;
      r_w_d        = 1'b1;
      ce0_d        = 1'b1;
      ce1_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               pop_s        = 1'b1;
               draw_color_d = head_s.color;
               case (head_s.opcode)
                  OP_PIXEL: begin
                     x_lo_d  = head_s.x1;
                     x_hi_d  = head_s.x1;
                     cur_x_d = head_s.x1;
                     cur_y_d = head_s.y1;
                     y_hi_d  = head_s.y1;
                     state_d = ST_DRAW;
                  end
                  OP_RECT: begin
                     x_lo_d  = min_x(head_s.x1, head_s.x2);
                     x_hi_d  = max_x(head_s.x1, head_s.x2);
                     cur_x_d = min_x(head_s.x1, head_s.x2);
                     cur_y_d = min_y(head_s.y1, head_s.y2);
                     y_hi_d  = max_y(head_s.y1, head_s.y2);
                     state_d = ST_DRAW;
                  end
                  OP_CLEAR: begin
                     x_lo_d  = 10'd0;
                     x_hi_d  = X_MAX;
                     cur_x_d = 10'd0;
                     cur_y_d = 9'd0;
                     y_hi_d  = Y_MAX;
                     state_d = ST_DRAW;
                  end
                  OP_SWAP: state_d = ST_SWAP;
                  default: state_d = ST_IDLE;
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAW: begin
            if (pix_ok_s) begin
               r_w_d  = 1'b0;
               ce0_d  = 1'b0;
               ce1_d  = 1'b1;
               rgb_d  = draw_color_q;
               addr_d = {buf_sel_q, cur_y_q, cur_x_q};
            end else begin
               r_w_d  = 1'b1;
            end
            // row-major walk: x wraps back to the left edge at the end of a row
            if (cur_x_q == x_hi_q) begin
               cur_x_d = x_lo_q;
               if (cur_y_q == y_hi_q) begin
                  state_d = ST_IDLE;
               end else begin
                  cur_y_d = cur_y_q + 9'd1;
               end
            end else begin
               cur_x_d = cur_x_q + 10'd1;
            end
         end
         ST_SWAP: begin
            buf_sel_d = ~buf_sel_q;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // all state and registered outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         color_q      <= 24'd0;
         p1_q         <= 19'd0;
         p2_q         <= 19'd0;
         state_q      <= ST_IDLE;
         cur_x_q      <= 10'd0;
         cur_y_q      <= 9'd0;
         x_lo_q       <= 10'd0;
         x_hi_q       <= 10'd0;
         y_hi_q       <= 9'd0;
         draw_color_q <= 24'd0;
         buf_sel_q    <= 1'b0;
         r_w_q        <= 1'b1;
         ce0_q        <= 1'b1;
         ce1_q        <= 1'b0;
         rgb_q        <= 24'd0;
         addr_q       <= 20'd0;
      end else begin
         color_q      <= color_d;
         p1_q         <= p1_d;
         p2_q         <= p2_d;
         state_q      <= state_d;
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         x_lo_q       <= x_lo_d;
         x_hi_q       <= x_hi_d;
         y_hi_q       <= y_hi_d;
         draw_color_q <= draw_color_d;
         buf_sel_q    <= buf_sel_d;
         r_w_q        <= r_w_d;
         ce0_q        <= ce0_d;
         ce1_q        <= ce1_d;
         rgb_q        <= rgb_d;
         addr_q       <= addr_d;
      end
   end

   assign R_W_o           = r_w_q;
   assign CE0_o           = ce0_q;
   assign CE1_o           = ce1_q;
   assign OE_o            = 1'b1;
   assign LB_o            = 1'b0;
   assign UB_o            = 1'b0;
   assign ZZ_o            = 1'b0;
   assign SEM_o           = 1'b1;
   assign rgbdataout_o    = rgb_q;
   assign adddataout_o    = addr_q;
   assign buffer_select_o = buf_sel_q;

endmodule

// File: tb/tb_gpu.sv
// tb_gpu: directed self-checking bench for gpu. Pixel writes are logged at
// the falling edge; each scenario compares the log and flags against
// hand-computed values.
module tb_gpu;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [31:0] pAddr_i, pDataWrite_i;
   logic        pSel_i, pEnable_i, pWrite_i;
   logic        CE0_o, CE1_o, LB_o, UB_o, R_W_o, OE_o, ZZ_o, SEM_o;
   logic [23:0] rgbdataout_o;
   logic [19:0] adddataout_o;
   logic        buffer_select_o, fifo_full_o;

   int n_checks = 0;
   int n_pass   = 0;

   logic [19:0] addr_log[$];
   logic [23:0] rgb_log[$];
   logic [4:0]  strb_log[$];

   gpu #(.FIFO_DEPTH(8)) dut (
      .clk             (clk),
      .n_rst           (n_rst),
      .pAddr_i         (pAddr_i),
      .pDataWrite_i    (pDataWrite_i),
      .pSel_i          (pSel_i),
      .pEnable_i       (pEnable_i),
      .pWrite_i        (pWrite_i),
      .CE0_o           (CE0_o),
      .CE1_o           (CE1_o),
      .LB_o            (LB_o),
      .UB_o            (UB_o),
      .R_W_o           (R_W_o),
      .OE_o            (OE_o),
      .ZZ_o            (ZZ_o),
      .SEM_o           (SEM_o),
      .rgbdataout_o    (rgbdataout_o),
      .adddataout_o    (adddataout_o),
      .buffer_select_o (buffer_select_o),
      .fifo_full_o     (fifo_full_o)
   );

   always #5 clk = ~clk;

   // pixel write logger
   always @(negedge clk) begin
      if (R_W_o == 1'b0) begin
         addr_log.push_back(adddataout_o);
         rgb_log.push_back(rgbdataout_o);
         strb_log.push_back({CE0_o, CE1_o, OE_o, LB_o, UB_o});
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      pSel_i = 1'b1; pWrite_i = 1'b1; pEnable_i = 1'b0;
      pAddr_i = addr; pDataWrite_i = data;
      @(negedge clk);
      pEnable_i = 1'b1;
      @(posedge clk);
      #1;
      pSel_i = 1'b0; pEnable_i = 1'b0; pWrite_i = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log();
      addr_log.delete();
      rgb_log.delete();
      strb_log.delete();
   endtask

   function automatic logic [31:0] log_addr(input int i);
      return (addr_log.size() > i) ? {12'd0, addr_log[i]} : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] log_rgb(input int i);
      return (rgb_log.size() > i) ? {8'd0, rgb_log[i]} : 32'hFFFF_FFFF;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_rst = 1'b0;
      pAddr_i = 32'd0; pDataWrite_i = 32'd0;
      pSel_i = 1'b0; pEnable_i = 1'b0; pWrite_i = 1'b0;
      wait_cycles(3);

      // reset state
      check_val("rst_r_w", {31'd0, R_W_o}, 32'd1);
      check_val("rst_ce0", {31'd0, CE0_o}, 32'd1);
      check_val("rst_ce1", {31'd0, CE1_o}, 32'd0);
      check_val("rst_oe_lb_ub", {29'd0, OE_o, LB_o, UB_o}, 32'd4);
      check_val("rst_zz_sem", {30'd0, ZZ_o, SEM_o}, 32'd1);
      check_val("rst_rgb", {8'd0, rgbdataout_o}, 32'd0);
      check_val("rst_addr", {12'd0, adddataout_o}, 32'd0);
      check_val("rst_bufsel", {31'd0, buffer_select_o}, 32'd0);
      check_val("rst_full", {31'd0, fifo_full_o}, 32'd0);
      n_rst = 1'b1;
      wait_cycles(2);

      // single pixel with latency: push at edge N, write cycle from edge N+2
      clear_log();
      apb_wr(32'h0, 32'h00FF_0000);
      apb_wr(32'h4, 32'd5 | (32'd3 << 10));
      apb_wr(32'hC, 32'd1);
      @(negedge clk);
      check_val("pix_lat_n", {31'd0, R_W_o}, 32'd1);
      @(negedge clk);
      check_val("pix_lat_n1", {31'd0, R_W_o}, 32'd1);
      @(negedge clk);
      check_val("pix_lat_n2", {31'd0, R_W_o}, 32'd0);
      check_val("pix_addr", {12'd0, adddataout_o}, 32'd3077);
      check_val("pix_rgb", {8'd0, rgbdataout_o}, 32'd16711680);
      @(negedge clk);
      check_val("pix_end", {31'd0, R_W_o}, 32'd1);
      wait_cycles(5);
      check_val("pix_count", addr_log.size(), 32'd1);

      // reversed-corner rectangle
      clear_log();
      apb_wr(32'h4, 32'd2 | (32'd1 << 10));
      apb_wr(32'h8, 32'd1);
      apb_wr(32'hC, 32'd2);
      wait_cycles(12);
      check_val("rect_count", addr_log.size(), 32'd4);
      check_val("rect_a0", log_addr(0), 32'd1);
      check_val("rect_a1", log_addr(1), 32'd2);
      check_val("rect_a2", log_addr(2), 32'd1025);
      check_val("rect_a3", log_addr(3), 32'd1026);
      check_val("rect_rgb", log_rgb(3), 32'hFF_0000);

      // swap then pixel at origin
      clear_log();
      apb_wr(32'h4, 32'd0);
      apb_wr(32'hC, 32'd4);
      apb_wr(32'hC, 32'd1);
      wait_cycles(8);
      check_val("swap_bufsel", {31'd0, buffer_select_o}, 32'd1);
      check_val("swap_count", addr_log.size(), 32'd1);
      check_val("swap_addr", log_addr(0), 32'd524288);
      check_val("swap_strb", (strb_log.size() > 0) ? {27'd0, strb_log[0]} : 32'hFFFF_FFFF, 32'b01100);

      // undefined opcode acts as NOP
      clear_log();
      apb_wr(32'hC, 32'd6);
      wait_cycles(6);
      check_val("nop_count", addr_log.size(), 32'd0);

      // row crossing the right edge of the field
      clear_log();
      apb_wr(32'h0, 32'h0012_3456);
      apb_wr(32'h4, 32'd638);
      apb_wr(32'h8, 32'd641);
      apb_wr(32'hC, 32'd2);
      wait_cycles(10);
      check_val("edge_a0", log_addr(0), 32'd524926);
      check_val("edge_a1", log_addr(1), 32'd524927);
      check_val("edge_rgb", log_rgb(0), 32'h12_3456);
`ifdef GPU_CLIP_EN
      check_val("edge_count", addr_log.size(), 32'd2);
`else
      check_val("edge_count", addr_log.size(), 32'd4);
      check_val("edge_a3", log_addr(3), 32'd524929);
`endif

      // ninth push while busy is dropped; verified by draining the queue
      clear_log();
      apb_wr(32'h4, 32'd0);
      apb_wr(32'h8, 32'd9 | (32'd9 << 10));
      apb_wr(32'hC, 32'd2);
      for (int i = 0; i < 9; i++) begin
         apb_wr(32'h4, (32'd20 + 32'(i)) | (32'd5 << 10));
         apb_wr(32'hC, 32'd1);
         if (i == 6) check_val("drop_full7", {31'd0, fifo_full_o}, 32'd0);
         if (i == 7) check_val("drop_full8", {31'd0, fifo_full_o}, 32'd1);
         if (i == 8) check_val("drop_full9", {31'd0, fifo_full_o}, 32'd1);
      end
      wait_cycles(200);
      check_val("drop_full_clr", {31'd0, fifo_full_o}, 32'd0);
      check_val("drop_count", addr_log.size(), 32'd108);
      check_val("drop_rect_last", log_addr(99), 32'd533513);
      check_val("drop_first_pix", log_addr(100), 32'd529428);
      check_val("drop_last_pix", log_addr(107), 32'd529435);

      // CLEAR keeps the rasterizer busy while the queue fills, then reset
      clear_log();
      apb_wr(32'hC, 32'd3);
      for (int i = 0; i < 9; i++) begin
         apb_wr(32'hC, 32'd1);
         if (i == 7) check_val("clr_full8", {31'd0, fifo_full_o}, 32'd1);
         if (i == 8) check_val("clr_full9", {31'd0, fifo_full_o}, 32'd1);
      end
      wait_cycles(5);
      check_val("clr_busy", {31'd0, R_W_o}, 32'd0);
      #2;
      n_rst = 1'b0;
      #1;
      check_val("mid_rst_r_w", {31'd0, R_W_o}, 32'd1);
      check_val("mid_rst_full", {31'd0, fifo_full_o}, 32'd0);
      check_val("mid_rst_bufsel", {31'd0, buffer_select_o}, 32'd0);
      check_val("mid_rst_addr", {12'd0, adddataout_o}, 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      clear_log();
      wait_cycles(20);
      check_val("post_rst_idle", addr_log.size(), 32'd0);

      // staging registers were cleared: a bare PIXEL lands at 0 with colour 0
      apb_wr(32'hC, 32'd1);
      wait_cycles(6);
      check_val("post_rst_count", addr_log.size(), 32'd1);
      check_val("post_rst_addr", log_addr(0), 32'd0);
      check_val("post_rst_rgb", log_rgb(0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gpu.md
GPU -- requirements
Module: gpu

Interface
REQ-001 Parameter: FIFO_DEPTH, default 8, command FIFO entries (power of two, at least 2).
REQ-002 Ports use shared widths: CHANNEL_BITS=8, WIDTH_BITS=10, HEIGHT_BITS=9.
REQ-003 clk  in  1  sole clock; all logic on the rising edge.
REQ-004 n_rst  in  1  reset, asynchronous and active-low.
REQ-005 pAddr_i  in  32  APB address; bits [3:2] decoded.
REQ-006 pDataWrite_i  in  32  APB write data.
REQ-007 pSel_i, pEnable_i, pWrite_i  in  1 each  APB select, enable and write.
REQ-008 CE0_o, CE1_o, LB_o, UB_o, R_W_o, OE_o, ZZ_o, SEM_o  out  1 each  SRAM control.
REQ-009 rgbdataout_o  out  24  pixel colour {R,G,B}.
REQ-010 adddataout_o  out  20  pixel address {buffer_select, y[8:0], x[9:0]}.
REQ-011 buffer_select_o  out  1  back buffer currently drawn.
REQ-012 fifo_full_o  out  1  command FIFO full.

Function
REQ-013 APB access is write-only and zero-wait; an access completes on an edge with pSel_i & pEnable_i & pWrite_i high.
REQ-014 Address 0x0 loads COLOR[23:0]; 0x4 loads P1 (x=[9:0], y=[18:10]); 0x8 loads P2 in the same format.
REQ-015 Address 0xC pushes {opcode=pDataWrite_i[2:0], COLOR, P1, P2} into the FIFO; staging registers stay unchanged.
REQ-016 Opcodes: 0 NOP, 1 PIXEL (P1), 2 RECT (filled, P1..P2 inclusive), 3 CLEAR (whole 640x480 field), 4 SWAP (toggle buffer_select_o); opcodes 5-7 act as NOP.
REQ-017 A push is accepted only if the FIFO is not full at that edge; a push while full is silently dropped, even if a pop occurs on the same edge.
REQ-018 fifo_full_o is registered and is high while count == FIFO_DEPTH.
REQ-019 Rasterizer FSM has states IDLE, DRAW and SWAP.
REQ-020 IDLE: if the FIFO is non-empty, pop and go to DRAW (PIXEL/RECT/CLEAR), to SWAP (SWAP), or stay in IDLE (NOP).
REQ-021 DRAW emits one pixel per cycle in row-major order, x fastest, then returns to IDLE after the last pixel.
REQ-022 RECT corners are normalised per axis, so x2 < x1 or y2 < y1 still draws min..max.
REQ-023 SWAP toggles buffer_select_o in one cycle, then returns to IDLE.
REQ-024 Pixel write cycle: R_W_o=0, CE0_o=0, CE1_o=1, LB_o=UB_o=0, OE_o=1; rgbdataout_o and adddataout_o are valid in that cycle.
REQ-025 Non-write cycle: R_W_o=1, CE0_o=1, CE1_o=0, OE_o=1.
REQ-026 ZZ_o=0 and SEM_o=1 at all times.
REQ-027 Latency: a command pushed at edge N into an empty FIFO while IDLE produces its first R_W_o=0 cycle starting at edge N+2.
REQ-028 All outputs are registered.

Reset
REQ-029 n_rst low immediately: FIFO empty, fifo_full_o=0, FSM IDLE, buffer_select_o=0, COLOR/P1/P2=0, R_W_o=1, CE0_o=1, CE1_o=0, OE_o=1, LB_o=UB_o=0, ZZ_o=0, SEM_o=1, rgbdataout_o=0, adddataout_o=0.
REQ-030 Reset during DRAW aborts the command; no further pixels of it are written.

Configuration
REQ-031 Macro GPU_CLIP_EN defined: pixels with x>639 or y>479 are skipped (no write cycle; the raster still advances).
REQ-032 GPU_CLIP_EN undefined: coordinates are written unmodified, field-width modulo.

Structure
REQ-033 Package gpu_pkg holds the width constants, opcode enum, command struct and the screen limits 640/480.
REQ-034 The FIFO is sub-module gpu_cmd_fifo; decode and the FSM stay in gpu.

Verification
REQ-035 COLOR=0xFF0000, P1=(5,3), CMD=1 -> exactly one write, adddataout_o=3*1024+5=3077, rgb=16711680.
REQ-036 RECT P1=(2,1), P2=(1,0) -> four writes, addresses 1,2,1025,1026 in that order.
REQ-037 SWAP then PIXEL (0,0) -> buffer_select_o=1, adddataout_o=524288.
REQ-038 Nine pushes with the rasterizer held busy by CLEAR -> fifo_full_o=1 after 8 queued entries, ninth dropped.
REQ-039 GPU_CLIP_EN, RECT (638,0)-(641,0) -> two writes only (x=638,639).
REQ-040 n_rst pulsed low mid-CLEAR -> R_W_o=1 and the FIFO is empty immediately.
